// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: next-PC select, imem valid/ready request, redirect
// buffering while stalled, and trapping of misaligned register-jump targets.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       npc_op,
  input  logic             op_valid,
  input  logic [25:0]      imm,
  input  logic [31:0]      rs_val,
  input  logic             stall,
  input  logic             imem_ready,
  output logic [31:0]      pc,
  output logic             pc_valid,
  output logic             exc,
  output logic [31:0]      bad_addr,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam logic [1:0] NPC_PLUS4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH   = 2'b01;
  localparam logic [1:0] NPC_JUMP_IMM = 2'b10;
  localparam logic [1:0] NPC_JUMP_REG = 2'b11;

  logic             pend;
  logic             pend_exc;
  logic [31:0]      pend_tgt;

  logic             pend_n;
  logic             pend_exc_n;
  logic [31:0]      pend_tgt_n;
  logic [31:0]      pc_n;
  logic             pc_valid_n;
  logic             exc_n;
  logic [31:0]      bad_addr_n;
  logic [CNT_W-1:0] fetch_cnt_n;

  logic [1:0]       sel_op;
  logic [31:0]      p4;
  logic [31:0]      raw_tgt;
  logic [31:0]      eff_tgt;
  logic             adv;
  logic             redirect;
  logic             trap;

  // Target computation for the instruction currently at pc
  always_comb begin
    sel_op   = op_valid ? npc_op : NPC_PLUS4;
    p4       = pc + 32'd4;
    raw_tgt  = p4;
    case (sel_op)
      NPC_BRANCH:   raw_tgt = p4 + {{14{imm[15]}}, imm[15:0], 2'b00};
      NPC_JUMP_IMM: raw_tgt = {p4[31:28], imm, 2'b00};
      NPC_JUMP_REG: raw_tgt = rs_val;
      default:      raw_tgt = p4;
    endcase
    redirect = (sel_op != NPC_PLUS4);
    trap     = (sel_op == NPC_JUMP_REG) && (rs_val[1:0] != 2'b00);
    eff_tgt  = trap ? EXC_VEC : raw_tgt;
    adv      = pc_valid && imem_ready && !stall;
  end

  // Next-state: a buffered redirect always wins over the current-cycle inputs
  always_comb begin
    pc_n        = pc;
    pc_valid_n  = 1'b1;
    exc_n       = 1'b0;
    bad_addr_n  = bad_addr;
    fetch_cnt_n = fetch_cnt;
    pend_n      = pend;
    pend_exc_n  = pend_exc;
    pend_tgt_n  = pend_tgt;
    if (adv) begin
      fetch_cnt_n = fetch_cnt + CNT_W'(1);
      if (pend) begin
        pc_n       = pend_tgt;
        exc_n      = pend_exc;
        pend_n     = 1'b0;
        pend_exc_n = 1'b0;
      end else begin
        pc_n = eff_tgt;
        if (trap) begin
          exc_n      = 1'b1;
          bad_addr_n = rs_val;
        end
      end
    end else if (!pend && redirect) begin
      pend_n     = 1'b1;
      pend_tgt_n = eff_tgt;
      pend_exc_n = trap;
      if (trap) begin
        bad_addr_n = rs_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      pc_valid  <= 1'b0;
      exc       <= 1'b0;
      bad_addr  <= 32'd0;
      fetch_cnt <= '0;
      pend      <= 1'b0;
      pend_exc  <= 1'b0;
      pend_tgt  <= 32'd0;
    end else begin
      pc        <= pc_n;
      pc_valid  <= pc_valid_n;
      exc       <= exc_n;
      bad_addr  <= bad_addr_n;
      fetch_cnt <= fetch_cnt_n;
      pend      <= pend_n;
      pend_exc  <= pend_exc_n;
      pend_tgt  <= pend_tgt_n;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed plan sequences plus random traffic,
// checked against a behavioural next-PC model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;
  localparam int unsigned CW     = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    npc_op = 2'b00;
  logic          op_valid = 1'b0;
  logic [25:0]   imm = '0;
  logic [31:0]   rs_val = '0;
  logic          stall = 1'b0;
  logic          imem_ready = 1'b0;
  logic [31:0]   pc;
  logic          pc_valid;
  logic          exc;
  logic [31:0]   bad_addr;
  logic [CW-1:0] fetch_cnt;

  pc_fetch_unit #(.RESET_PC(RST_PC), .EXC_VEC(EXC_PC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .npc_op(npc_op), .op_valid(op_valid), .imm(imm),
    .rs_val(rs_val), .stall(stall), .imem_ready(imem_ready), .pc(pc),
    .pc_valid(pc_valid), .exc(exc), .bad_addr(bad_addr), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        exc;
    logic [31:0] bad;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  logic [31:0] m_pc, m_ptgt, m_bad;
  logic        m_valid, m_pend, m_pexc, m_exc;
  int          m_cnt;

  function automatic exp_t snap();
    exp_t e;
    e.pc = m_pc; e.v = m_valid; e.exc = m_exc; e.bad = m_bad; e.cnt = 4'(m_cnt);
    return e;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_valid = 1'b0; m_pend = 1'b0; m_pexc = 1'b0;
    m_ptgt = '0; m_bad = '0; m_exc = 1'b0; m_cnt = 0;
  endtask

  // One clock edge of the architectural rules
  task automatic model_step();
    logic [31:0] p4, tgt;
    logic        go, redir, trp;
    int          off;
    p4    = m_pc + 32'd4;
    redir = op_valid && (npc_op != 2'b00);
    trp   = redir && (npc_op == 2'b11) && (rs_val % 4 != 0);
    off   = int'($signed(imm[15:0]));
    if (!redir)              tgt = p4;
    else if (npc_op == 2'b01) tgt = p4 + 32'(off * 4);
    else if (npc_op == 2'b10) tgt = (p4 & 32'hF000_0000) | (32'(imm) * 32'd4);
    else                      tgt = rs_val;
    if (trp) tgt = EXC_PC;
    go    = m_valid && imem_ready && !stall;
    m_exc = 1'b0;
    if (go) begin
      m_cnt = (m_cnt + 1) % 16;
      if (m_pend) begin
        m_pc = m_ptgt; m_exc = m_pexc; m_pend = 1'b0;
      end else begin
        m_pc = tgt;
        if (trp) begin m_exc = 1'b1; m_bad = rs_val; end
      end
    end else if (!m_pend && redir) begin
      m_pend = 1'b1; m_ptgt = tgt; m_pexc = trp;
      if (trp) m_bad = rs_val;
    end
    m_valid = 1'b1;
  endtask

  task automatic cyc(input logic ov, input logic [1:0] op, input logic [25:0] im,
                     input logic [31:0] rs, input logic st, input logic rdy);
    @(negedge clk);
    rst_n = 1'b1; op_valid = ov; npc_op = op; imm = im; rs_val = rs;
    stall = st; imem_ready = rdy;
    model_step();
    q.push_back(snap());
  endtask

  // Asynchronous reset mid-cycle with an immediate check of the cleared state
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    op_valid = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (pc !== RST_PC || pc_valid !== 1'b0 || exc !== 1'b0 || fetch_cnt !== 4'd0 ||
        bad_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset: pc=%h valid=%b exc=%b cnt=%0d bad=%h (exp pc=%h, rest zero)",
               pc, pc_valid, exc, fetch_cnt, bad_addr, RST_PC);
    end
    q.push_back(snap());
    @(negedge clk);
    q.push_back(snap());
  endtask

  // Monitor: compares every presented output cycle with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (pc !== e.pc || pc_valid !== e.v || exc !== e.exc || bad_addr !== e.bad ||
            fetch_cnt !== e.cnt) begin
          miscompares++;
          $display("FAIL vec%0d @%0t: got pc=%h v=%b exc=%b bad=%h cnt=%0d exp pc=%h v=%b exc=%b bad=%h cnt=%0d",
                   vectors, $time, pc, pc_valid, exc, bad_addr, fetch_cnt,
                   e.pc, e.v, e.exc, e.bad, e.cnt);
        end
      end
    end
  end

  initial begin
    logic [31:0] r;
    model_reset();
    q.push_back(snap());
    @(negedge clk);
    q.push_back(snap());
    // Reset release, sequential fetch
    for (int i = 0; i < 5; i++) cyc(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
    // Branches from 0x3010: backward and forward
    cyc(1'b1, 2'b11, '0, 32'h3010, 1'b0, 1'b1);
    cyc(1'b1, 2'b01, 26'h000FFFE, '0, 1'b0, 1'b1);
    cyc(1'b1, 2'b11, '0, 32'h3010, 1'b0, 1'b1);
    cyc(1'b1, 2'b01, 26'h0000003, '0, 1'b0, 1'b1);
    // Immediate jump from 0x3000, aligned and misaligned register jumps
    cyc(1'b1, 2'b11, '0, 32'h3000, 1'b0, 1'b1);
    cyc(1'b1, 2'b10, 26'h0000C10, '0, 1'b0, 1'b1);
    cyc(1'b1, 2'b11, '0, 32'h3104, 1'b0, 1'b1);
    cyc(1'b1, 2'b11, '0, 32'h3102, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
    // Buffered redirect: first capture wins over a later conflicting one
    cyc(1'b1, 2'b11, '0, 32'h3000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b01, 26'h000000F, '0, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, '0, 32'h5000, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, '0, 32'h5000, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
    // Trap captured under stall; exc follows the later advance
    cyc(1'b1, 2'b11, '0, 32'h3102, 1'b1, 1'b1);
    cyc(1'b1, 2'b01, 26'h0000010, '0, 1'b1, 1'b1);
    cyc(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
    // Pending redirect discarded by async reset
    cyc(1'b1, 2'b11, '0, 32'h5000, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
    // Counter wrap: 18 straight accepted fetches
    for (int i = 0; i < 18; i++) cyc(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) r = r | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 26'($urandom),
               r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer end of the NPCOp interface. Holds the architectural PC and computes the next PC from the NPCOp code, the immediate field and the register operand.
- Issues fetch requests to instruction memory through a valid/ready handshake.
- Buffers a redirect that arrives while the fetch is stalled, and traps misaligned register-jump targets.
- Sits between the control/branch logic and the instruction memory port.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, PC loaded when a misaligned JR target traps.
- CNT_W, 16, width of the accepted-fetch counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- npc_op  in  2  next-PC select, using the NPC_* encodings from ctrl_encode_def.v: PLUS4=00, BRANCH=01, JUMP_IMM=10, JUMP_REG=11.
- op_valid  in  1  npc_op, imm and rs_val belong to the instruction at the current pc.
- imm  in  26  [15:0] branch offset; [25:0] jump index.
- rs_val  in  32  register target for JUMP_REG.
- stall  in  1  pipeline hold; blocks PC advance.
- imem_ready  in  1  instruction memory accepts the request.
- pc  out  32  current fetch address.
- pc_valid  out  1  fetch request valid.
- exc  out  1  one-cycle pulse when a misaligned JR target is taken.
- bad_addr  out  32  last trapped target.
- fetch_cnt  out  CNT_W  count of accepted fetches.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, pc_valid=0, exc=0, bad_addr=0, fetch_cnt=0, pend=0, pend_tgt=0.
  - The first rising edge with rst_n=1 sets pc_valid=1. pc_valid stays 1 until the next reset.
- adv = pc_valid & imem_ready & ~stall.
- Target, all arithmetic mod 2^32, with p4 = pc+4:
  - PLUS4 = p4.
  - BRANCH = p4 + (sign-extend imm[15:0] << 2).
  - JUMP_IMM = {p4[31:28], imm[25:0], 2'b00}.
  - JUMP_REG = rs_val.
  - When op_valid=0, npc_op is treated as PLUS4.
- Redirect = op_valid & npc_op≠PLUS4.
- Trap = redirect & npc_op==JUMP_REG & rs_val[1:0]≠0.
  - Effective target becomes EXC_VEC.
  - Raw rs_val is the value saved to bad_addr.
- Next-PC selection when adv=1, in priority order:
  1. pend=1: pc<=pend_tgt, pend<=0. Current-cycle inputs are ignored; they belong to the already-redirected instruction.
  2. Otherwise pc<=effective target.
  - In both cases fetch_cnt<=fetch_cnt+1, wrapping to 0 at 2^CNT_W.
- When adv=0, pend=0 and redirect=1:
  - pend<=1 and pend_tgt<=effective target; pc holds.
  - If trapping: bad_addr<=rs_val now; exc waits for the advance.
- When adv=0 and pend=1: pend_tgt holds, first capture wins, and later redirects are ignored.
- exc timing:
  - exc=1 for exactly the one cycle following the edge on which pc is loaded with EXC_VEC because of a trap. That load is either the direct path or the pend path with a trapped target; a 1-bit pend_exc flag travels with pend_tgt.
  - On the direct path, bad_addr is updated on the same edge.
- Stall and handshake:
  - stall=1 or imem_ready=0 holds pc, pc_valid and fetch_cnt.
  - pc is stable while pc_valid=1 and imem_ready=0.
- Simultaneous events:
  - stall with redirect goes to pend capture.
  - imem_ready rising in the same cycle pend is set: pend is consumed on that advance.
- Reset mid-operation: the async assert clears all state immediately, including a pending redirect.

Test Plan:
- Reset release with imem_ready=1, no redirect:
  - pc sequence 0x3000, 0x3004, 0x3008.
  - pc_valid rises one cycle after rst_n deassert.
  - fetch_cnt = 1, 2, 3.
- BRANCH:
  - pc=0x3010, imm[15:0]=16'hFFFE -> next pc 0x300C.
  - imm=16'h0003 -> 0x3020.
- JUMP_IMM at pc=0x3000 with imm=26'h0000C10 -> pc 0x0000_3040.
- JUMP_REG with rs_val=0x0000_3104 -> pc 0x3104, exc=0.
- JUMP_REG with rs_val=0x3102:
  - pc -> 0x4180 and exc=1 for one cycle; bad_addr=0x3102.
- Redirect buffering:
  - imem_ready=0 for 3 cycles while BRANCH to 0x3040 presents, then a conflicting JUMP_REG 0x5000 presents.
  - When ready rises: pc -> 0x3040, fetch_cnt +1 only.
- Reset mid-operation:
  - Assert rst_n=0 while pend=1 -> pc=0x3000 immediately, pend and fetch_cnt cleared, no exc.
- fetch_cnt with CNT_W=4: 16 accepted fetches -> wraps to 0.
